// File: rtl/bpa_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bpa_op_sequencer
// Purpose  : Clocked operand sequencer and result capture stage for an
//            external WIDTH-bit ripple-carry adder. Operands are latched on an
//            accepted start and presented to the adder from registers. The
//            block waits SETTLE_CYC cycles for the ripple chain to resolve,
//            then captures sum/carry. In accumulate mode the previous sum is
//            fed back as operand A.
// Macro    : BPA_ACC_SAT_EN - when defined, an accumulate-mode carry-out
//            saturates result/acc to all ones instead of wrapping.
// Ports    : clk, rst_n (async, active low)
//            start, acc_mode, clr              - control
//            a_in, b_in, c_in_in               - operand sources
//            add_sum, add_cout                 - returned from adder
//            add_a, add_b, add_cin             - registered operands to adder
//            result, carry, ovf, busy, done    - status / results
// Revision : 1.0 - initial release
// ============================================================================
module bpa_op_sequencer #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 2    // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             acc_mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in_in,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETTLE  = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;

    // Counter reloads with SETTLE_CYC-1 so that CAPTURE is entered exactly
    // SETTLE_CYC edges after start is accepted.
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode_acc;   // mode latched at acceptance
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_cin;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_cap_val;    // value written to result and acc
    logic             w_acc_ovf;    // carry-out of an accumulate operation

    assign w_acc_ovf = r_mode_acc & add_cout;

    always_comb begin
        w_cap_val = add_sum;
`ifdef BPA_ACC_SAT_EN
        if (w_acc_ovf) begin
            w_cap_val = '1;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 4'd0;
            r_acc      <= '0;
            r_mode_acc <= 1'b0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_cin  <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                // Abort any operation; adder operands are left untouched.
                r_state  <= c_IDLE;
                r_cnt    <= 4'd0;
                r_acc    <= '0;
                r_result <= '0;
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            if (acc_mode) begin
                                r_add_a   <= r_acc;
                                r_add_cin <= 1'b0;
                            end else begin
                                r_add_a   <= a_in;
                                r_add_cin <= c_in_in;
                            end
                            r_add_b    <= b_in;
                            r_mode_acc <= acc_mode;
                            r_cnt      <= c_SETTLE_LOAD;
                            r_busy     <= 1'b1;
                            r_state    <= c_SETTLE;
                        end
                    end
                    c_SETTLE: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= c_CAPTURE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    c_CAPTURE: begin
                        r_result <= w_cap_val;
                        r_acc    <= w_cap_val;
                        r_carry  <= add_cout;
                        if (w_acc_ovf) begin
                            r_ovf <= 1'b1;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign add_cin = r_add_cin;
    assign result  = r_result;
    assign carry   = r_carry;
    assign ovf     = r_ovf;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bpa_op_sequencer.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_bpa_op_sequencer
// Purpose  : Self-checking bench for bpa_op_sequencer. Includes a behavioural
//            ripple adder and an arithmetic reference model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpa_op_sequencer;

    localparam int WIDTH      = 4;
    localparam int SETTLE_CYC = 2;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             acc_mode = 1'b0;
    logic             clr      = 1'b0;
    logic [WIDTH-1:0] a_in     = '0;
    logic [WIDTH-1:0] b_in     = '0;
    logic             c_in_in  = 1'b0;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             busy;
    logic             done;

    bpa_op_sequencer #(
        .WIDTH      (WIDTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc_mode (acc_mode),
        .clr      (clr),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in_in  (c_in_in),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .result   (result),
        .carry    (carry),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural adder returning sum/carry from the registered operands.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_acc     = '0;
    logic [WIDTH-1:0] m_result  = '0;
    logic             m_carry   = 1'b0;
    logic             m_ovf     = 1'b0;
    logic [WIDTH-1:0] m_add_a   = '0;
    logic [WIDTH-1:0] m_add_b   = '0;
    logic             m_add_cin = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_operands(input string tag);
        chkw({tag, ".add_a"}, add_a, m_add_a);
        chkw({tag, ".add_b"}, add_b, m_add_b);
        chk1({tag, ".add_cin"}, add_cin, m_add_cin);
    endtask

    task automatic chk_results(input string tag);
        chkw({tag, ".result"}, result, m_result);
        chk1({tag, ".carry"}, carry, m_carry);
        chk1({tag, ".ovf"}, ovf, m_ovf);
    endtask

    task automatic model_clear();
        m_acc    = '0;
        m_result = '0;
        m_carry  = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic wait_no_done(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk1({tag, ".done_idle"}, done, 1'b0);
            chk1({tag, ".busy_idle"}, busy, 1'b0);
        end
    endtask

    // One complete operation with cycle-accurate latency checking.
    task automatic run_op(input string tag, input logic mode, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic c, input bit repulse);
        logic [WIDTH:0] s;
        @(negedge clk);
        acc_mode = mode;
        a_in     = a;
        b_in     = b;
        c_in_in  = c;
        start    = 1'b1;
        if (mode) begin
            m_add_a   = m_acc;
            m_add_cin = 1'b0;
            s = {1'b0, m_acc} + {1'b0, b};
        end else begin
            m_add_a   = a;
            m_add_cin = c;
            s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        end
        m_add_b = b;
        // Past the accepting edge: scramble sources, they must not matter.
        @(negedge clk);
        start    = repulse;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
        c_in_in  = 1'($urandom);
        acc_mode = 1'($urandom);
        chk1({tag, ".busy0"}, busy, 1'b1);
        chk1({tag, ".done0"}, done, 1'b0);
        chk_operands({tag, ".accept"});
        for (int j = 1; j <= SETTLE_CYC; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk1({tag, ".busy"}, busy, 1'b1);
            chk1({tag, ".done_early"}, done, 1'b0);
            chk_operands({tag, ".settle"});
        end
        m_carry  = s[WIDTH];
        m_result = s[WIDTH-1:0];
`ifdef BPA_ACC_SAT_EN
        if (mode && s[WIDTH]) m_result = '1;
`endif
        m_acc = m_result;
        if (mode && s[WIDTH]) m_ovf = 1'b1;
        @(negedge clk);
        chk1({tag, ".done"}, done, 1'b1);
        chk1({tag, ".busy_end"}, busy, 1'b0);
        chk_results(tag);
        @(negedge clk);
        chk1({tag, ".done_pulse"}, done, 1'b0);
        chk_operands({tag, ".hold"});
    endtask

    initial begin
        // Reset state
        #2;
        chkw("rst.add_a", add_a, '0);
        chkw("rst.add_b", add_b, '0);
        chk1("rst.add_cin", add_cin, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.done", done, 1'b0);
        chk_results("rst");
        #10 rst_n = 1'b1;

        // Directed cases
        run_op("add_5_3_1", 1'b0, 4'h5, 4'h3, 1'b1, 1'b0);
        chkw("add_5_3_1.r9", result, 4'h9);
        run_op("add_F_1_0", 1'b0, 4'hF, 4'h1, 1'b0, 1'b0);
        chkw("add_F_1_0.r0", result, 4'h0);
        chk1("add_F_1_0.c1", carry, 1'b1);

        // clr in idle
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
        chk_results("clr_idle");
        chk_operands("clr_idle");

        // Three accumulations of 6
        run_op("acc1", 1'b1, 4'h0, 4'h6, 1'b1, 1'b0);
        chkw("acc1.r", result, 4'h6);
        run_op("acc2", 1'b1, 4'h0, 4'h6, 1'b1, 1'b0);
        chkw("acc2.r", result, 4'hC);
        run_op("acc3", 1'b1, 4'h0, 4'h6, 1'b1, 1'b0);
`ifdef BPA_ACC_SAT_EN
        chkw("acc3.r", result, 4'hF);
`else
        chkw("acc3.r", result, 4'h2);
`endif
        chk1("acc3.ovf", ovf, 1'b1);

        // start re-pulsed during SETTLE must be ignored
        run_op("repulse", 1'b0, 4'hA, 4'h4, 1'b0, 1'b1);
        wait_no_done("repulse", SETTLE_CYC + 2);

        // clr during SETTLE aborts without done
        @(negedge clk);
        acc_mode = 1'b0; a_in = 4'h3; b_in = 4'h7; c_in_in = 1'b1; start = 1'b1;
        m_add_a = 4'h3; m_add_b = 4'h7; m_add_cin = 1'b1;
        @(negedge clk); start = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
        chk1("clr_mid.busy", busy, 1'b0);
        chk1("clr_mid.done", done, 1'b0);
        chk_results("clr_mid");
        chk_operands("clr_mid");
        wait_no_done("clr_mid", SETTLE_CYC + 2);

        // start and clr together: clr wins
        @(negedge clk);
        a_in = 4'hE; b_in = 4'hD; c_in_in = 1'b0; start = 1'b1; clr = 1'b1;
        @(negedge clk); start = 1'b0; clr = 1'b0;
        chk1("clr_start.busy", busy, 1'b0);
        chk_operands("clr_start");
        wait_no_done("clr_start", SETTLE_CYC + 2);

        // Async reset mid-SETTLE
        run_op("pre_rst", 1'b0, 4'h6, 4'h6, 1'b1, 1'b0);
        @(negedge clk);
        acc_mode = 1'b0; a_in = 4'h7; b_in = 4'h2; c_in_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 rst_n = 1'b0;
        #0.5;
        model_clear();
        m_add_a = '0; m_add_b = '0; m_add_cin = 1'b0;
        chk1("async_rst.busy", busy, 1'b0);
        chk1("async_rst.done", done, 1'b0);
        chk_results("async_rst");
        chk_operands("async_rst");
        #0.5 rst_n = 1'b1;
        wait_no_done("async_rst", SETTLE_CYC + 2);

        // Randomised operations against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); clr = 1'b1;
                @(negedge clk); clr = 1'b0;
                model_clear();
                chk_results("rnd_clr");
            end
            run_op("rnd", 1'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpa_op_sequencer.md
Name: bpa_op_sequencer

Overview:
- Clocked operand sequencer and result capture stage wrapped around the 4-bit ripple-carry adder.
- Upstream side: latches operands and carry-in from switch-level inputs, then drives them to the adder as stable registered signals.
- Waits a programmable settle time so the ripple chain resolves.
- Downstream side: captures sum/carry into result registers, with an accumulate mode that feeds the previous sum back as operand A.

Parameters:
- WIDTH, 4, operand/sum width; must match adder width.
- SETTLE_CYC, 2, clock cycles allowed for the ripple chain to settle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin an add; sampled in IDLE only.
- acc_mode  input  1  0 = add a_in+b_in+c_in_in; 1 = add acc+b_in (carry-in forced 0).
- clr  input  1  synchronous clear of accumulator, result and flags.
- a_in  input  WIDTH  operand A source.
- b_in  input  WIDTH  operand B source.
- c_in_in  input  1  carry-in source (non-accumulate mode).
- add_sum  input  WIDTH  sum returned from adder (s3..s0).
- add_cout  input  1  carry-out returned from adder.
- add_a  output  WIDTH  registered operand A to adder.
- add_b  output  WIDTH  registered operand B to adder.
- add_cin  output  1  registered carry-in to adder.
- result  output  WIDTH  last captured sum.
- carry  output  1  last captured carry-out.
- ovf  output  1  sticky: any carry-out in accumulate mode since last clr/reset.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result/carry update.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs and the internal acc register 0; settle counter 0.
- FSM states: IDLE, SETTLE, CAPTURE.
- IDLE, start=1:
  - acc_mode=0: add_a<=a_in, add_b<=b_in, add_cin<=c_in_in.
  - acc_mode=1: add_a<=acc, add_b<=b_in, add_cin<=0.
  - Operands and mode are latched at this edge; counter<=SETTLE_CYC-1; busy<=1; go to SETTLE.
- SETTLE: hold add_a/add_b/add_cin stable. Counter decrements each cycle; when counter==0, go to CAPTURE.
- CAPTURE:
  - result<=add_sum, carry<=add_cout, acc<=add_sum.
  - If the latched mode is accumulate and add_cout=1, ovf<=1.
  - done<=1 for one cycle; busy<=0; go to IDLE.
- Latency: start sampled at edge E, done/result valid after edge E+SETTLE_CYC+1. With SETTLE_CYC=2 this is 3 edges.
- start while busy: ignored, no queueing. start and clr in the same cycle: clr wins, start dropped.
- clr (any state): acc, result, carry, ovf<=0; state<=IDLE; busy<=0; no done pulse. An in-flight operation is aborted. add_a/add_b/add_cin keep their values.
- Arithmetic: modulo 2^WIDTH. add_cout is the only overflow indication. acc wraps unless ACC_SAT_EN is defined.
- a_in/b_in changes after acceptance have no effect until the next start.
- done is never high on two consecutive cycles.

Optional Feature:
- Macro: BPA_ACC_SAT_EN.
- Defined: in accumulate mode, if add_cout=1 at CAPTURE, result and acc are set to all ones (saturate) instead of add_sum. carry and ovf still set to 1. Non-accumulate mode is unchanged.
- Undefined: wrap-around; result=acc=add_sum always.

Test Plan:
- Reset mid-SETTLE (rst_n low 1 ns, async) -> all outputs 0 immediately, FSM IDLE, no done.
- a_in=4'h5, b_in=4'h3, c_in_in=1, acc_mode=0, start -> add_a=5, add_b=3, add_cin=1. Adder model returns 9; done after 3 edges, result=4'h9, carry=0.
- a_in=4'hF, b_in=4'h1, c_in_in=0 -> result=4'h0, carry=1, ovf stays 0.
- clr, then three accumulate starts with b_in=4'h6:
  - Without BPA_ACC_SAT_EN: results 6, C, 2; carry on 3rd; ovf=1.
  - With BPA_ACC_SAT_EN: results 6, C, F; ovf=1.
- start re-pulsed during SETTLE -> ignored, exactly one done. clr asserted in SETTLE -> busy drops next cycle, no done, result=0.
- SETTLE_CYC=1 and SETTLE_CYC=5 builds -> done exactly 2 and 6 edges after start; add_a/add_b/add_cin stable throughout busy.
